// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one pipelined adder among NUM_REQ requesters.
// Define ADDER_SHARE_STATS_EN to add saturating per-requester grant counters.
module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arb_en,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic [WIDTH-1:0]         add_x,
  output logic [WIDTH-1:0]         add_y,
  input  logic [WIDTH-1:0]         add_out,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
`ifdef ADDER_SHARE_STATS_EN
  input  logic                     stat_clr,
  output logic [NUM_REQ*16-1:0]    stat_grants,
`endif
  output logic                     busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      rr_next;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_id;
  logic               hs;
  logic               found;
  logic [IW:0]        idx;

  logic [LATENCY-1:0] tag_v;
  logic [IW-1:0]      tag_id [LATENCY];

  // Search from rr_ptr upward with wrap; first requester found wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    if (rst_n && arb_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = {1'b0, rr_ptr} + (IW+1)'(k);
        if (idx >= (IW+1)'(NUM_REQ)) begin
          idx = idx - (IW+1)'(NUM_REQ);
        end
        if (!found && req_valid[idx[IW-1:0]]) begin
          found  = 1'b1;
          gnt_id = idx[IW-1:0];
          gnt[idx[IW-1:0]] = 1'b1;
        end
      end
    end
  end

  assign hs        = found;
  assign req_ready = gnt;

  always_comb begin
    add_x = '0;
    add_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        add_x = req_x[i*WIDTH +: WIDTH];
        add_y = req_y[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    if (hs) begin
      if (gnt_id == IW'(NUM_REQ-1)) begin
        rr_next = '0;
      end else begin
        rr_next = gnt_id + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_next;
    end
  end

  // Tag pipeline mirrors the adder latency; it never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      tag_v[0]  <= hs;
      tag_id[0] <= gnt_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign busy = |tag_v;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_v[LATENCY-1] && tag_id[LATENCY-1] == IW'(i)) begin
        rsp_valid[i] = 1'b1;
      end
    end
  end

  // Gate by tag valid so stale adder output never leaks out.
  assign rsp_data = tag_v[LATENCY-1] ? add_out : '0;

`ifdef ADDER_SHARE_STATS_EN
  logic [15:0] cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stat_clr) begin
          cnt[i] <= '0;
        end else if (gnt[i] && cnt[i] != 16'hFFFF) begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grants[i*16 +: 16] = cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: queue-based reference model plus
// directed vectors with hand-computed results.
module tb_adder_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           arb_en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [W-1:0]   add_x;
  logic [W-1:0]   add_y;
  logic [W-1:0]   add_out;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;
`ifdef ADDER_SHARE_STATS_EN
  logic           stat_clr;
  logic [N*16-1:0] stat_grants;
`endif

  int checks = 0;
  int errors = 0;

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .arb_en(arb_en),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x(req_x),
    .req_y(req_y),
    .add_x(add_x),
    .add_y(add_y),
    .add_out(add_out),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
`ifdef ADDER_SHARE_STATS_EN
    .stat_clr(stat_clr),
    .stat_grants(stat_grants),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Adder: registered operands, registered sum, no reset.
  logic [W-1:0] ax_q, ay_q;
  always @(posedge clk) begin
    ax_q    <= add_x;
    ay_q    <= add_y;
    add_out <= ax_q + ay_q;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] rr(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
    end
    return '0;
  endfunction

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] sum;
  } rsp_t;

  rsp_t         q[$];
  int           ptr = 0;
  int           cyc = 0;
  int           gid;
  logic [N-1:0] eg, ev;
  logic [W-1:0] ex, ey, ed;

  // Reference model and per-cycle compare.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_add_x", 64'(add_x), 64'd0);
      q.delete();
      ptr = 0;
    end else begin
      eg  = arb_en ? rr(req_valid, ptr) : '0;
      ex  = '0;
      ey  = '0;
      gid = -1;
      for (int i = 0; i < N; i++) begin
        if (eg[i]) begin
          ex  = req_x[i*W +: W];
          ey  = req_y[i*W +: W];
          gid = i;
        end
      end
      chk("m_ready", 64'(req_ready), 64'(eg));
      chk("m_add_x", 64'(add_x), 64'(ex));
      chk("m_add_y", 64'(add_y), 64'(ey));
      chk("m_busy", 64'(busy), 64'(q.size() != 0));
      ev = '0;
      ed = '0;
      if (q.size() != 0 && q[0].due == cyc) begin
        ev = N'(1) << q[0].id;
        ed = q[0].sum;
        void'(q.pop_front());
      end
      chk("m_rsp_valid", 64'(rsp_valid), 64'(ev));
      chk("m_rsp_data", 64'(rsp_data), 64'(ed));
      if (gid >= 0) begin
        q.push_back('{due: cyc + LAT, id: gid, sum: ex + ey});
        ptr = (gid + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic opnd(input int i, input logic [W-1:0] x,
                      input logic [W-1:0] y);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
  endtask

  logic [N-1:0] seq [5];

  initial begin
    rst_n     = 1'b0;
    arb_en    = 1'b1;
    req_valid = '1;
    req_x     = '0;
    req_y     = '0;
`ifdef ADDER_SHARE_STATS_EN
    stat_clr  = 1'b0;
`endif
    @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    step();
    rst_n     = 1'b1;
    req_valid = '0;

    // Single op from requester 2
    step();
    req_valid = 4'b0100;
    opnd(2, 32'd5, 32'd7);
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'h4);
    chk("single_add_x", 64'(add_x), 64'd5);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("single_busy1", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    chk("single_rsp_v", 64'(rsp_valid), 64'h4);
    chk("single_rsp_d", 64'(rsp_data), 64'd12);
    chk("single_busy2", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    chk("single_busy3", 64'(busy), 64'd0);

    // All four requesting continuously from reset
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) opnd(i, 32'(i * 10 + 1), 32'd100);
    req_valid = 4'b1111;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_order", 64'(req_ready), 64'(seq[k]));
      step();
    end
    req_valid = '0;
    @(negedge clk);
    chk("rr_rsp3_v", 64'(rsp_valid), 64'h8);
    chk("rr_rsp3_d", 64'(rsp_data), 64'd131);
    step();
    @(negedge clk);
    chk("rr_rsp0_v", 64'(rsp_valid), 64'h1);
    chk("rr_rsp0_d", 64'(rsp_data), 64'd101);

    // Modulo wrap of the sum
    step();
    req_valid = 4'b0001;
    opnd(0, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    chk("wrap_ready0", 64'(req_ready), 64'h1);
    step();
    req_valid = 4'b1000;
    opnd(3, 32'h8000_0000, 32'h8000_0000);
    @(negedge clk);
    chk("wrap_ready3", 64'(req_ready), 64'h8);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("wrap_rsp0_v", 64'(rsp_valid), 64'h1);
    chk("wrap_rsp0_d", 64'(rsp_data), 64'd0);
    step();
    @(negedge clk);
    chk("wrap_rsp3_v", 64'(rsp_valid), 64'h8);
    chk("wrap_rsp3_d", 64'(rsp_data), 64'd0);

    // arb_en drop: no grants, in-flight op drains
    step();
    req_valid = 4'b0010;
    opnd(1, 32'd3, 32'd4);
    @(negedge clk);
    chk("en_ready1", 64'(req_ready), 64'h2);
    step();
    arb_en    = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("en_off_ready", 64'(req_ready), 64'd0);
    chk("en_off_busy", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    chk("en_rsp_v", 64'(rsp_valid), 64'h2);
    chk("en_rsp_d", 64'(rsp_data), 64'd7);
    step();
    req_valid = '0;
    arb_en    = 1'b1;
    @(negedge clk);
    chk("en_busy_low", 64'(busy), 64'd0);

    // Reset one cycle after a grant
    step();
    req_valid = 4'b0100;
    opnd(2, 32'd9, 32'd9);
    @(negedge clk);
    chk("mid_ready", 64'(req_ready), 64'h4);
    step();
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_no_rsp", 64'(rsp_valid), 64'd0);
    step();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("mid_first_gnt", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;

    // Mixed traffic checked by the model
    for (int k = 0; k < 40; k++) begin
      step();
      req_valid = N'($urandom);
      arb_en    = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) opnd(i, $urandom, $urandom);
    end
    step();
    req_valid = '0;
    arb_en    = 1'b1;
    repeat (4) step();

`ifdef ADDER_SHARE_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    req_valid = 4'b0010;
    repeat (70000) step();
    req_valid = '0;
    @(negedge clk);
    chk("stat_sat", 64'(stat_grants[31:16]), 64'hFFFF);
    step();
    req_valid = 4'b0010;
    stat_clr  = 1'b1;
    step();
    stat_clr  = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("stat_clr", 64'(stat_grants[31:16]), 64'd0);
    repeat (3) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
